// File: rtl/twiddle_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : twiddle_seq_pkg
//  Desc     : Shared types, default sizes and the twiddle address rule for
//             twiddle_seq.
//  Revision : 1.0
// ============================================================================
package twiddle_seq_pkg;

    localparam int C_LOG2N = 6;
    localparam int C_DW    = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Stage s uses only the low s bits of b, scaled up to the full ROM range.
    function automatic int unsigned tw_addr(input int unsigned log2n,
                                            input int unsigned s,
                                            input int unsigned b);
        int unsigned w_mask;
        w_mask = (32'd1 << s) - 32'd1;
        return (b & w_mask) << (log2n - 32'd1 - s);
    endfunction

endpackage
`default_nettype wire

// File: rtl/twiddle_seq_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : twiddle_seq_addr_gen
//  Desc     : Stage/butterfly counters, end-of-stage and end-of-sweep flags,
//             and the combinational twiddle ROM address.
//  Revision : 1.0
// ============================================================================
module twiddle_seq_addr_gen
    import twiddle_seq_pkg::*;
#(
    parameter int LOG2N = C_LOG2N,
    parameter int AW    = LOG2N - 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_step,
    output logic [2:0]    o_stage,
    output logic [AW-1:0] o_idx,
    output logic          o_eos,
    output logic          o_last,
    output logic [AW-1:0] o_rom_addr
);

    localparam logic [AW-1:0] C_B_MAX = '1;
    localparam logic [2:0]    C_S_MAX = 3'(LOG2N - 1);

    logic [2:0]    r_stage;
    logic [AW-1:0] r_idx;
    logic          w_eos;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stage <= '0;
            r_idx   <= '0;
        end else if (i_clr) begin
            r_stage <= '0;
            r_idx   <= '0;
        end else if (i_step) begin
            if (r_idx == C_B_MAX) begin
                r_idx   <= '0;
                r_stage <= r_stage + 3'd1;
            end else begin
                r_idx   <= r_idx + AW'(1);
            end
        end
    end

    assign w_eos      = (r_idx == C_B_MAX);
    assign o_stage    = r_stage;
    assign o_idx      = r_idx;
    assign o_eos      = w_eos;
    assign o_last     = w_eos && (r_stage == C_S_MAX);
    // Counters hold outside RUN, so the address holds with them.
    assign o_rom_addr = AW'(tw_addr(32'(LOG2N), 32'(r_stage), 32'(r_idx)));

endmodule
`default_nettype wire

// File: rtl/twiddle_seq.sv
`default_nettype none
// ============================================================================
//  Module   : twiddle_seq
//  Desc     : Walks all radix-2 DIT FFT stages/butterflies, addresses the
//             external twiddle ROM and streams registered twiddles over a
//             valid/ready handshake. Optional TWIDDLE_SEQ_INV_EN adds the
//             inv input for conjugated (IFFT) twiddles.
//  Revision : 1.0
// ============================================================================
module twiddle_seq
    import twiddle_seq_pkg::*;
#(
    parameter int LOG2N = C_LOG2N,
    parameter int AW    = LOG2N - 1,
    parameter int DW    = C_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
`ifdef TWIDDLE_SEQ_INV_EN
    input  logic          inv,
`endif
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_re,
    input  logic [DW-1:0] rom_im,
    output logic          tw_valid,
    input  logic          tw_ready,
    output logic [DW-1:0] tw_re,
    output logic [DW-1:0] tw_im,
    output logic [2:0]    tw_stage,
    output logic [AW-1:0] tw_idx,
    output logic          tw_eos,
    output logic          tw_last
);

    state_t        r_state;
    state_t        w_next;
    logic          w_adv;
    logic          w_clr;
    logic          w_load;
    logic          w_step;
    logic          w_done;
    logic [2:0]    w_cnt_stage;
    logic [AW-1:0] w_cnt_idx;
    logic          w_cnt_eos;
    logic          w_cnt_last;
    logic [DW-1:0] w_im;

    logic          r_tw_valid;
    logic [DW-1:0] r_tw_re;
    logic [DW-1:0] r_tw_im;
    logic [2:0]    r_tw_stage;
    logic [AW-1:0] r_tw_idx;
    logic          r_tw_eos;
    logic          r_tw_last;

    twiddle_seq_addr_gen #(
        .LOG2N (LOG2N),
        .AW    (AW)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_clr),
        .i_step     (w_step),
        .o_stage    (w_cnt_stage),
        .o_idx      (w_cnt_idx),
        .o_eos      (w_cnt_eos),
        .o_last     (w_cnt_last),
        .o_rom_addr (rom_addr)
    );

    assign w_adv = !r_tw_valid || tw_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_clr  = 1'b0;
        w_load = 1'b0;
        w_step = 1'b0;
        w_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = ST_RUN;
                    w_clr  = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_adv) begin
                    w_load = 1'b1;
                    // The final beat leaves the counters parked on it.
                    if (w_cnt_last) begin
                        w_next = ST_DRAIN;
                    end else begin
                        w_step = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (r_tw_valid && tw_ready && r_tw_last) begin
                    w_next = ST_IDLE;
                    w_done = 1'b1;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

`ifdef TWIDDLE_SEQ_INV_EN
    localparam logic [DW-1:0] C_IM_MIN = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] C_IM_MAX = {1'b0, {(DW-1){1'b1}}};

    logic r_inv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inv <= 1'b0;
        end else if (w_clr) begin
            r_inv <= inv;
        end
    end

    // Negating the most negative value saturates instead of wrapping.
    always_comb begin
        w_im = rom_im;
        if (r_inv) begin
            w_im = (rom_im == C_IM_MIN) ? C_IM_MAX : -rom_im;
        end
    end
`else
    assign w_im = rom_im;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tw_valid <= 1'b0;
            r_tw_re    <= '0;
            r_tw_im    <= '0;
            r_tw_stage <= '0;
            r_tw_idx   <= '0;
            r_tw_eos   <= 1'b0;
            r_tw_last  <= 1'b0;
        end else if (w_load) begin
            r_tw_valid <= 1'b1;
            r_tw_re    <= rom_re;
            r_tw_im    <= w_im;
            r_tw_stage <= w_cnt_stage;
            r_tw_idx   <= w_cnt_idx;
            r_tw_eos   <= w_cnt_eos;
            r_tw_last  <= w_cnt_last;
        end else if ((r_state == ST_DRAIN) && tw_ready) begin
            r_tw_valid <= 1'b0;
        end
    end

    assign busy     = (r_state != ST_IDLE);
    assign done     = w_done;
    assign tw_valid = r_tw_valid;
    assign tw_re    = r_tw_re;
    assign tw_im    = r_tw_im;
    assign tw_stage = r_tw_stage;
    assign tw_idx   = r_tw_idx;
    assign tw_eos   = r_tw_eos;
    assign tw_last  = r_tw_last;

endmodule
`default_nettype wire

// File: tb/tb_twiddle_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_twiddle_seq
//  Desc     : Scoreboard bench for twiddle_seq with a behavioural twiddle ROM.
//  Revision : 1.0
// ============================================================================
module tb_twiddle_seq;

    localparam int AW     = 5;
    localparam int DW     = 16;
    localparam int NBEAT  = 192;
    localparam int M_FULL  = 0;
    localparam int M_BP    = 1;
    localparam int M_START = 2;
    localparam int M_RAND  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_re;
    logic [DW-1:0] rom_im;
    logic          tw_valid;
    logic          tw_ready;
    logic [DW-1:0] tw_re;
    logic [DW-1:0] tw_im;
    logic [2:0]    tw_stage;
    logic [AW-1:0] tw_idx;
    logic          tw_eos;
    logic          tw_last;
`ifdef TWIDDLE_SEQ_INV_EN
    logic          inv;
`endif

    typedef struct packed {
        logic [2:0]    s;
        logic [AW-1:0] b;
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic          eos;
        logic          last;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_exp;
    exp_t mon_got;
    int checks   = 0;
    int errors   = 0;
    int beat_cnt = 0;
    int done_cnt = 0;
    int eos_cnt  = 0;
    int last_cnt = 0;

    always #5 clk = ~clk;

    twiddle_seq dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
`ifdef TWIDDLE_SEQ_INV_EN
        .inv      (inv),
`endif
        .busy     (busy),
        .done     (done),
        .rom_addr (rom_addr),
        .rom_re   (rom_re),
        .rom_im   (rom_im),
        .tw_valid (tw_valid),
        .tw_ready (tw_ready),
        .tw_re    (tw_re),
        .tw_im    (tw_im),
        .tw_stage (tw_stage),
        .tw_idx   (tw_idx),
        .tw_eos   (tw_eos),
        .tw_last  (tw_last)
    );

    function automatic logic [DW-1:0] rom_re_f(input logic [AW-1:0] a);
        return {3'b000, a, 8'hA5};
    endfunction

    function automatic logic [DW-1:0] rom_im_f(input logic [AW-1:0] a);
        return (a == 5'd8) ? 16'h8000 : 16'h1234 + {3'b000, a, 8'h00};
    endfunction

    assign rom_re = rom_re_f(rom_addr);
    assign rom_im = rom_im_f(rom_addr);

    function automatic logic [AW-1:0] exp_addr(input int s, input int b);
        return AW'((b % (1 << s)) * (32 >> s));
    endfunction

    function automatic logic [DW-1:0] exp_im(input logic [AW-1:0] a, input logic iv);
        logic [DW-1:0] v;
        v = rom_im_f(a);
        if (iv) v = (v == 16'h8000) ? 16'h7FFF : (16'h0000 - v);
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got %h required %h", name, got, req);
        end
    endtask

    task automatic push_sweep(input logic iv);
        exp_t e;
        for (int s = 0; s < 6; s++) begin
            for (int b = 0; b < 32; b++) begin
                e.s    = 3'(s);
                e.b    = AW'(b);
                e.re   = rom_re_f(exp_addr(s, b));
                e.im   = exp_im(exp_addr(s, b), iv);
                e.eos  = (b == 31);
                e.last = (s == 5) && (b == 31);
                exp_q.push_back(e);
            end
        end
    endtask

    // Scoreboard monitor: pops one expected beat per handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (tw_valid && tw_ready) begin
                beat_cnt++;
                if (tw_eos)  eos_cnt++;
                if (tw_last) last_cnt++;
                checks++;
                mon_got = {tw_stage, tw_idx, tw_re, tw_im, tw_eos, tw_last};
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL beat_unexpected got %h required none", mon_got);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_got !== mon_exp) begin
                        errors++;
                        $display("FAIL beat got %h required %h", mon_got, mon_exp);
                    end
                end
            end
            if (done) done_cnt++;
        end
    end

    task automatic run_sweep(input int mode, input logic iv);
        int d0, b0, e0, l0;
        bit ok, bp, pulsed;
        ok = 0; bp = 0; pulsed = 0;
        push_sweep(iv);
        d0 = done_cnt; b0 = beat_cnt; e0 = eos_cnt; l0 = last_cnt;
        @(posedge clk); #1;
        start = 1'b1;
`ifdef TWIDDLE_SEQ_INV_EN
        inv = iv;
`endif
        tw_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("run_after_start", 64'({busy, tw_valid}), 64'b10);
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk); #1;
            if (done_cnt != d0) begin
                ok = 1;
                break;
            end
            if (cyc == 0) check("first_valid_latency", 64'(tw_valid), 64'd1);
            tw_ready = (mode == M_RAND) ? ($urandom_range(3) != 0) : 1'b1;
            if (mode == M_START && !pulsed && (beat_cnt - b0) >= 50) begin
                start  = 1'b1;
                pulsed = 1;
            end else begin
                start = 1'b0;
            end
            if (mode == M_BP && !bp && tw_valid && tw_stage == 3'd2 && tw_idx == 5'd5) begin
                bp = 1;
                tw_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(posedge clk); #1;
                    check("bp_frozen", 64'({tw_valid, tw_stage, tw_idx, tw_re, tw_im}),
                          64'({1'b1, 3'd2, 5'd5, 16'h08A5, 16'h8000}));
                end
                tw_ready = 1'b1;
            end
            #1;
            if (mode == M_START && done) start = 1'b1;
        end
        start = 1'b0;
        tw_ready = 1'b1;
        check("sweep_done_seen", 64'(ok), 64'd1);
        check("idle_after_done", 64'({busy, tw_valid}), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        check("still_idle", 64'({busy, tw_valid}), 64'd0);
        check("beats_per_sweep", 64'(beat_cnt - b0), 64'(NBEAT));
        check("done_per_sweep", 64'(done_cnt - d0), 64'd1);
        check("eos_per_sweep", 64'(eos_cnt - e0), 64'd6);
        check("last_per_sweep", 64'(last_cnt - l0), 64'd1);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        if (mode == M_BP) check("bp_seen", 64'(bp), 64'd1);
        if (mode == M_START) check("start50_pulsed", 64'(pulsed), 64'd1);
    endtask

    task automatic reset_mid_sweep();
        int d0;
        bit hit;
        hit = 0;
        d0 = done_cnt;
        push_sweep(1'b0);
        @(posedge clk); #1;
        start = 1'b1;
        tw_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            @(posedge clk); #1;
            if (tw_valid && tw_stage == 3'd3 && tw_idx == 5'd10) begin
                hit = 1;
                break;
            end
        end
        check("reach_stage3", 64'(hit), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_outputs",
              64'({busy, done, rom_addr, tw_valid, tw_re, tw_im, tw_stage, tw_idx, tw_eos, tw_last}),
              64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("no_done_on_abort", 64'(done_cnt - d0), 64'd0);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        tw_ready = 1'b1;
`ifdef TWIDDLE_SEQ_INV_EN
        inv      = 1'b0;
`endif
        #12;
        check("reset_outputs",
              64'({busy, done, rom_addr, tw_valid, tw_re, tw_im, tw_stage, tw_idx, tw_eos, tw_last}),
              64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_sweep(M_FULL, 1'b0);
        run_sweep(M_BP, 1'b0);
        run_sweep(M_START, 1'b0);
        reset_mid_sweep();
        run_sweep(M_FULL, 1'b0);
`ifdef TWIDDLE_SEQ_INV_EN
        run_sweep(M_FULL, 1'b1);
`endif
        for (int n = 0; n < 10; n++) begin
            run_sweep(M_RAND, 1'b0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
